// File: rtl/ctx_pkg.sv
// Shared constants and types for the per-tile context loader.
package ctx_pkg;

    localparam int MASK_W      = 16;
    localparam int SEL_BIT     = 16;
    localparam int IM_BASE_LSB = 17;
    localparam int IM_BASE_W   = 6;
    localparam int CRF_BASE_W  = 5;
    localparam int ADDR_W      = 23;
    localparam int WORD_W      = 64;
    localparam int INSTR_W     = 21;
    localparam int CONST_W     = 24;

    localparam logic [4:0] OPC_HALT = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOADED,
        ST_RUN,
        ST_DONE
    } tile_state_t;

endpackage

// File: rtl/ctx_unpack.sv
// Splits one DMA context word into per-slot IM / CRF write enables, addresses and data.
module ctx_unpack
    import ctx_pkg::*;
#(
    parameter int TILE_ID   = 0,
    parameter int IM_DEPTH  = 64,
    parameter int CRF_DEPTH = 32,
    localparam int IM_AW    = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1,
    localparam int CRF_AW   = (CRF_DEPTH > 1) ? $clog2(CRF_DEPTH) : 1
) (
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [WORD_W-1:0]             wr_data,
    output logic                          hit,
    output logic                          im_sel,
    output logic [2:0]                    im_we,
    output logic [2:0][IM_AW-1:0]         im_addr,
    output logic [2:0][INSTR_W-1:0]       im_data,
    output logic [IM_BASE_W:0]            im_hi,
    output logic [1:0]                    crf_we,
    output logic [1:0][CRF_AW-1:0]        crf_addr,
    output logic [1:0][CONST_W-1:0]       crf_data
);

    localparam logic [IM_BASE_W:0]  IM_LIM  = (IM_BASE_W + 1)'(IM_DEPTH);
    localparam logic [CRF_BASE_W:0] CRF_LIM = (CRF_BASE_W + 1)'(CRF_DEPTH);

    logic [IM_BASE_W-1:0]  im_base;
    logic [CRF_BASE_W-1:0] crf_base;
    logic                  crf_sel;
    logic [IM_BASE_W:0]    im_sum;
    logic [CRF_BASE_W:0]   crf_sum;
    logic [IM_BASE_W:0]    im_top;
    logic                  unused_bits;

    // Bits 63 and [63:48] carry no payload; other tiles' mask bits are not ours to look at.
    assign unused_bits = ^{wr_data[WORD_W-1], wr_data[WORD_W-1:2*CONST_W], wr_addr};

    // Slot decode: slots past the top of either memory are dropped, never wrapped.
    always_comb begin
        hit      = wr_en & wr_addr[TILE_ID];
        im_sel   = hit & ~wr_addr[SEL_BIT];
        crf_sel  = hit & wr_addr[SEL_BIT];
        im_base  = wr_addr[IM_BASE_LSB +: IM_BASE_W];
        crf_base = wr_addr[IM_BASE_LSB +: CRF_BASE_W];
        im_sum   = '0;
        crf_sum  = '0;
        im_we    = '0;
        im_addr  = '0;
        im_data  = '0;
        crf_we   = '0;
        crf_addr = '0;
        crf_data = '0;
        for (int k = 0; k < 3; k++) begin
            im_sum     = {1'b0, im_base} + (IM_BASE_W + 1)'(k);
            im_we[k]   = im_sel && (im_sum < IM_LIM);
            im_addr[k] = im_sum[IM_AW-1:0];
            im_data[k] = wr_data[k*INSTR_W +: INSTR_W];
        end
        for (int k = 0; k < 2; k++) begin
            crf_sum     = {1'b0, crf_base} + (CRF_BASE_W + 1)'(k);
            crf_we[k]   = crf_sel && (crf_sum < CRF_LIM);
            crf_addr[k] = crf_sum[CRF_AW-1:0];
            crf_data[k] = wr_data[k*CONST_W +: CONST_W];
        end
        im_top = {1'b0, im_base} + (IM_BASE_W + 1)'(3);
        im_hi  = (im_top > IM_LIM) ? IM_LIM : im_top;
    end

endmodule

// File: rtl/tile_ctx_loader.sv
// Per-tile context sink: stores DMA context words into IM/CRF and issues the loaded program.
module tile_ctx_loader
    import ctx_pkg::*;
#(
    parameter int TILE_ID   = 0,
    parameter int IM_DEPTH  = 64,
    parameter int CRF_DEPTH = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Wr_En_i,
    input  logic [22:0]        Wr_Addr_i,
    input  logic [63:0]        Wr_Data_i,
    input  logic               Exec_En_i,
    input  logic               Stall_i,
    input  logic [4:0]         Const_rd_addr_i,
    output logic [23:0]        Const_rd_data_o,
    output logic [20:0]        Instr_o,
    output logic               Instr_valid_o,
    output logic [5:0]         Pc_o,
    output logic               Loaded_o,
    output logic               Done_o,
    output logic               Load_err_o
);

    localparam int IM_AW  = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;
    localparam int CRF_AW = (CRF_DEPTH > 1) ? $clog2(CRF_DEPTH) : 1;
    localparam logic [5:0] CRF_LIM = 6'(CRF_DEPTH);

    logic [INSTR_W-1:0] im_mem  [IM_DEPTH];
    logic [CONST_W-1:0] crf_mem [CRF_DEPTH];

    tile_state_t          state;
    logic [5:0]           pc;
    logic [6:0]           inst_hi;
    logic [6:0]           inst_hi_nxt;
    logic [6:0]           hi_base;
    logic [INSTR_W-1:0]   instr_p1;
    logic                 vld_p1;
    logic                 loaded_q;
    logic                 done_q;
    logic                 err_q;

    logic                       hit;
    logic                       im_sel;
    logic                       wr_ok;
    logic [2:0]                 im_we;
    logic [2:0][IM_AW-1:0]      im_addr;
    logic [2:0][INSTR_W-1:0]    im_data;
    logic [6:0]                 im_hi;
    logic [1:0]                 crf_we;
    logic [1:0][CRF_AW-1:0]     crf_addr;
    logic [1:0][CONST_W-1:0]    crf_data;
    logic [INSTR_W-1:0]         cur_instr;
    logic                       last_instr;

    function automatic logic [6:0] max_hi(input logic [6:0] a, input logic [6:0] b);
        return (a > b) ? a : b;
    endfunction

    ctx_unpack #(
        .TILE_ID   (TILE_ID),
        .IM_DEPTH  (IM_DEPTH),
        .CRF_DEPTH (CRF_DEPTH)
    ) u_unpack (
        .wr_en    (Wr_En_i),
        .wr_addr  (Wr_Addr_i),
        .wr_data  (Wr_Data_i),
        .hit      (hit),
        .im_sel   (im_sel),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_data  (im_data),
        .im_hi    (im_hi),
        .crf_we   (crf_we),
        .crf_addr (crf_addr),
        .crf_data (crf_data)
    );

    // Writes are refused while the program is running; that case only raises the error flag.
    assign wr_ok      = hit && (state != ST_RUN);
    assign cur_instr  = im_mem[pc[IM_AW-1:0]];
    assign last_instr = (({1'b0, pc} + 7'd1) == inst_hi) || (cur_instr[20:16] == OPC_HALT);

    // Program extent: a hit from DONE starts a fresh context, so the old extent is discarded first.
    always_comb begin
        hi_base     = (state == ST_DONE) ? 7'd0 : inst_hi;
        inst_hi_nxt = inst_hi;
        if (wr_ok) begin
            inst_hi_nxt = im_sel ? max_hi(hi_base, im_hi) : hi_base;
        end
    end

    // IM / CRF storage, cleared by reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < IM_DEPTH; i++)  im_mem[i]  <= '0;
            for (int i = 0; i < CRF_DEPTH; i++) crf_mem[i] <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < 3; k++) begin
                if (im_we[k]) im_mem[im_addr[k]] <= im_data[k];
            end
            for (int k = 0; k < 2; k++) begin
                if (crf_we[k]) crf_mem[crf_addr[k]] <= crf_data[k];
            end
        end
    end

    // Load / run sequencer with registered status and issue outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            inst_hi  <= '0;
            instr_p1 <= '0;
            vld_p1   <= 1'b0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            inst_hi <= inst_hi_nxt;
            if (hit && (state == ST_RUN)) err_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    vld_p1 <= 1'b0;
                    if (hit) begin
                        state    <= ST_LOADED;
                        loaded_q <= 1'b1;
                    end
                end
                ST_LOADED: begin
                    vld_p1 <= 1'b0;
                    if (Exec_En_i && (inst_hi_nxt != 7'd0)) begin
                        state    <= ST_RUN;
                        pc       <= '0;
                        loaded_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!Stall_i) begin
                        instr_p1 <= cur_instr;
                        vld_p1   <= 1'b1;
                        if (last_instr) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            pc <= pc + 6'd1;
                        end
                    end else begin
                        vld_p1 <= 1'b0;
                    end
                end
                ST_DONE: begin
                    vld_p1 <= 1'b0;
                    if (hit) begin
                        state    <= ST_LOADED;
                        loaded_q <= 1'b1;
                        done_q   <= 1'b0;
                    end else if (Exec_En_i && (inst_hi != 7'd0)) begin
                        state  <= ST_RUN;
                        pc     <= '0;
                        done_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Const_rd_data_o = ({1'b0, Const_rd_addr_i} < CRF_LIM) ?
                             crf_mem[Const_rd_addr_i[CRF_AW-1:0]] : '0;
    assign Instr_o         = instr_p1;
    assign Instr_valid_o   = vld_p1;
    assign Pc_o            = pc;
    assign Loaded_o        = loaded_q;
    assign Done_o          = done_q;
    assign Load_err_o      = err_q;

endmodule

// File: tb/tb_tile_ctx_loader.sv
// Directed bench for tile_ctx_loader instantiated as tile 2.
module tb_tile_ctx_loader;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Wr_En_i = 1'b0;
    logic [22:0] Wr_Addr_i = '0;
    logic [63:0] Wr_Data_i = '0;
    logic        Exec_En_i = 1'b0;
    logic        Stall_i = 1'b0;
    logic [4:0]  Const_rd_addr_i = '0;
    logic [23:0] Const_rd_data_o;
    logic [20:0] Instr_o;
    logic        Instr_valid_o;
    logic [5:0]  Pc_o;
    logic        Loaded_o;
    logic        Done_o;
    logic        Load_err_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [20:0] exp_im [64];

    tile_ctx_loader #(.TILE_ID(2), .IM_DEPTH(64), .CRF_DEPTH(32)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Wr_En_i         (Wr_En_i),
        .Wr_Addr_i       (Wr_Addr_i),
        .Wr_Data_i       (Wr_Data_i),
        .Exec_En_i       (Exec_En_i),
        .Stall_i         (Stall_i),
        .Const_rd_addr_i (Const_rd_addr_i),
        .Const_rd_data_o (Const_rd_data_o),
        .Instr_o         (Instr_o),
        .Instr_valid_o   (Instr_valid_o),
        .Pc_o            (Pc_o),
        .Loaded_o        (Loaded_o),
        .Done_o          (Done_o),
        .Load_err_o      (Load_err_o)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0; Wr_En_i = 1'b0; Exec_En_i = 1'b0; Stall_i = 1'b0;
        Wr_Addr_i = '0; Wr_Data_i = '0; Const_rd_addr_i = '0;
        repeat (2) step();
        Reset = 1'b1;
        step();
    endtask

    task automatic wr_im(input logic [15:0] mask, input logic [5:0] base,
                         input logic [20:0] s0, input logic [20:0] s1, input logic [20:0] s2);
        Wr_Addr_i = {base, 1'b0, mask};
        Wr_Data_i = {1'b0, s2, s1, s0};
        Wr_En_i   = 1'b1;
        step();
        Wr_En_i   = 1'b0;
    endtask

    task automatic wr_crf(input logic [15:0] mask, input logic [4:0] base,
                          input logic [23:0] s0, input logic [23:0] s1);
        Wr_Addr_i = {1'b0, base, 1'b1, mask};
        Wr_Data_i = {16'h0, s1, s0};
        Wr_En_i   = 1'b1;
        step();
        Wr_En_i   = 1'b0;
    endtask

    // Pulse Exec, then follow issue until Done, expecting exp_im[0..n_exp-1] in order.
    task automatic run_check(input string tag, input int n_exp, input int st_lo, input int st_hi,
                             input logic [5:0] pc_end);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        Exec_En_i = 1'b1;
        step();
        Exec_En_i = 1'b0;
        check_val({tag, "_entry_vld"}, Instr_valid_o, 1'b0);
        while (!Done_o && cyc < 100) begin
            cyc++;
            Stall_i = (cyc >= st_lo) && (cyc <= st_hi);
            step();
            if (Stall_i) begin
                check_val({tag, "_stall_vld"}, Instr_valid_o, 1'b0);
                if (got > 0) check_val({tag, "_stall_hold"}, Instr_o, exp_im[got-1]);
            end else begin
                check_val({tag, "_vld"}, Instr_valid_o, 1'b1);
                if (got < 64) check_val({tag, "_instr"}, Instr_o, exp_im[got]);
                got++;
            end
        end
        Stall_i = 1'b0;
        check_val({tag, "_done"}, Done_o, 1'b1);
        check_val({tag, "_count"}, got, n_exp);
        check_val({tag, "_pc"}, Pc_o, pc_end);
        step();
        check_val({tag, "_post_vld"}, Instr_valid_o, 1'b0);
        check_val({tag, "_post_done"}, Done_o, 1'b1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check_val("rst_instr", Instr_o, 0);
        check_val("rst_vld", Instr_valid_o, 0);
        check_val("rst_pc", Pc_o, 0);
        check_val("rst_loaded", Loaded_o, 0);
        check_val("rst_done", Done_o, 0);
        check_val("rst_err", Load_err_o, 0);
        check_val("rst_crf", Const_rd_data_o, 0);

        // Mask miss: other tile's bit, both IM and CRF
        wr_im(16'h0008, 6'd0, 21'h1, 21'h2, 21'h3);
        check_val("miss_loaded", Loaded_o, 0);
        wr_crf(16'h0008, 5'd0, 24'h123456, 24'h654321);
        Const_rd_addr_i = 5'd0; #1;
        check_val("miss_crf0", Const_rd_data_o, 0);
        Const_rd_addr_i = 5'd1; #1;
        check_val("miss_crf1", Const_rd_data_o, 0);
        Exec_En_i = 1'b1; step(); Exec_En_i = 1'b0; step();
        check_val("idle_exec_vld", Instr_valid_o, 0);
        check_val("idle_exec_loaded", Loaded_o, 0);

        // Single IM word, then rerun from DONE
        wr_im(16'h0004, 6'd0, 21'h00001, 21'h00002, 21'h00003);
        check_val("single_loaded", Loaded_o, 1);
        for (int i = 0; i < 64; i++) exp_im[i] = '0;
        exp_im[0] = 21'h1; exp_im[1] = 21'h2; exp_im[2] = 21'h3;
        run_check("single", 3, 0, -1, 6'd2);
        run_check("rerun", 3, 0, -1, 6'd2);

        // Hit together with Exec in LOADED: fetch of PC 0 sees the new word
        do_reset();
        wr_im(16'h0004, 6'd0, 21'h11, 21'h12, 21'h13);
        Wr_Addr_i = {6'd0, 1'b0, 16'h0004};
        Wr_Data_i = {1'b0, 21'h23, 21'h22, 21'h21};
        Wr_En_i = 1'b1; Exec_En_i = 1'b1;
        step();
        Wr_En_i = 1'b0; Exec_En_i = 1'b0;
        step();
        check_val("simul_i0", Instr_o, 21'h21);
        step();
        check_val("simul_i1", Instr_o, 21'h22);
        step();
        check_val("simul_i2", Instr_o, 21'h23);
        check_val("simul_done", Done_o, 1);

        // Top-edge drops and CRF read-during-write
        do_reset();
        wr_crf(16'h0004, 5'd30, 24'hAAAAAA, 24'hBBBBBB);
        check_val("crf_loaded", Loaded_o, 1);
        Const_rd_addr_i = 5'd30; #1;
        check_val("crf30", Const_rd_data_o, 24'hAAAAAA);
        Const_rd_addr_i = 5'd31; #1;
        check_val("crf31", Const_rd_data_o, 24'hBBBBBB);
        Exec_En_i = 1'b1; step(); Exec_En_i = 1'b0; step();
        check_val("empty_exec_loaded", Loaded_o, 1);
        check_val("empty_exec_vld", Instr_valid_o, 0);
        Const_rd_addr_i = 5'd30;
        Wr_Addr_i = {1'b0, 5'd30, 1'b1, 16'h0004};
        Wr_Data_i = {16'h0, 24'hBBBBBB, 24'h111111};
        Wr_En_i = 1'b1;
        #1;
        check_val("rdw_old", Const_rd_data_o, 24'hAAAAAA);
        step();
        Wr_En_i = 1'b0;
        check_val("rdw_new", Const_rd_data_o, 24'h111111);
        wr_crf(16'h0004, 5'd31, 24'hCCCCCC, 24'hDDDDDD);
        Const_rd_addr_i = 5'd31; #1;
        check_val("crf31_top", Const_rd_data_o, 24'hCCCCCC);
        Const_rd_addr_i = 5'd0; #1;
        check_val("crf0_nowrap", Const_rd_data_o, 0);
        wr_im(16'h0004, 6'd63, 21'h0ABCD, 21'h12345, 21'h0F0F0);
        for (int i = 0; i < 64; i++) exp_im[i] = '0;
        exp_im[63] = 21'h0ABCD;
        run_check("top", 64, 0, -1, 6'd63);

        // Run with a two-cycle stall
        do_reset();
        wr_im(16'h0004, 6'd0, 21'h100, 21'h101, 21'h102);
        wr_im(16'h0004, 6'd3, 21'h103, 21'h104, 21'h105);
        for (int i = 0; i < 6; i++) exp_im[i] = 21'h100 + 21'(i);
        run_check("stall", 6, 3, 4, 6'd5);

        // HALT opcode in slot 2
        do_reset();
        wr_im(16'h0004, 6'd0, 21'h10, 21'h11, 21'h1F0022);
        wr_im(16'h0004, 6'd3, 21'h13, 21'h14, 21'h15);
        exp_im[0] = 21'h10; exp_im[1] = 21'h11; exp_im[2] = 21'h1F0022;
        run_check("halt", 3, 0, -1, 6'd2);

        // Hit during RUN, reload from DONE, then reset mid-run
        do_reset();
        wr_im(16'h0004, 6'd0, 21'h200, 21'h201, 21'h202);
        wr_im(16'h0004, 6'd3, 21'h203, 21'h204, 21'h205);
        Exec_En_i = 1'b1; step(); Exec_En_i = 1'b0;
        Wr_Addr_i = {6'd0, 1'b0, 16'h0004};
        Wr_Data_i = {1'b0, 21'h3AAAC, 21'h3AAAB, 21'h3AAAA};
        Wr_En_i = 1'b1;
        step();
        Wr_En_i = 1'b0;
        check_val("err_flag", Load_err_o, 1);
        check_val("err_i0", Instr_o, 21'h200);
        step();
        check_val("err_i1", Instr_o, 21'h201);
        for (int i = 0; i < 20 && !Done_o; i++) step();
        check_val("err_done", Done_o, 1);
        check_val("err_last", Instr_o, 21'h205);
        check_val("err_pc", Pc_o, 5);
        check_val("err_sticky", Load_err_o, 1);
        wr_im(16'h0004, 6'd0, 21'h30, 21'h31, 21'h32);
        check_val("reload_loaded", Loaded_o, 1);
        check_val("reload_done", Done_o, 0);
        exp_im[0] = 21'h30; exp_im[1] = 21'h31; exp_im[2] = 21'h32;
        run_check("reload", 3, 0, -1, 6'd2);
        Exec_En_i = 1'b1; step(); Exec_En_i = 1'b0;
        step();
        check_val("mid_instr", Instr_o, 21'h30);
        Reset = 1'b0;
        #1;
        check_val("arst_instr", Instr_o, 0);
        check_val("arst_vld", Instr_valid_o, 0);
        check_val("arst_pc", Pc_o, 0);
        check_val("arst_loaded", Loaded_o, 0);
        check_val("arst_done", Done_o, 0);
        check_val("arst_err", Load_err_o, 0);
        Reset = 1'b1;
        step();
        Exec_En_i = 1'b1; step(); Exec_En_i = 1'b0; step();
        check_val("arst_idle_vld", Instr_valid_o, 0);
        check_val("arst_idle_loaded", Loaded_o, 0);
        wr_im(16'h0004, 6'd3, 21'h41, 21'h42, 21'h43);
        exp_im[0] = 0; exp_im[1] = 0; exp_im[2] = 0;
        exp_im[3] = 21'h41; exp_im[4] = 21'h42; exp_im[5] = 21'h43;
        run_check("cleared", 6, 0, -1, 6'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
